// File: rtl/lpc_sniff_pkg.sv
// Shared definitions for the LPC sniffer record path: record geometry,
// header bit layout, serializer state type and byte-selection helpers.
package lpc_sniff_pkg;

  localparam int RECORD_BYTES = 9;
  localparam int RECORD_WIDTH = 72;

  // Header byte layout: {ct_dir, ovf, size}
  localparam int HDR_CT_MSB   = 7;
  localparam int HDR_CT_LSB   = 4;
  localparam int HDR_OVF_BIT  = 3;
  localparam int HDR_SIZE_MSB = 2;
  localparam int HDR_SIZE_LSB = 0;

  // Byte index inside a record, 0..RECORD_BYTES-1
  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RECORD_BYTES - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_t;

  // Assemble the header byte from the decoder fields and the overflow flag.
  function automatic logic [7:0] make_header(input logic [3:0] ct_dir,
                                             input logic       ovf,
                                             input logic [2:0] size);
    logic [7:0] hdr;
    hdr = 8'h00;
    hdr[HDR_CT_MSB:HDR_CT_LSB]     = ct_dir;
    hdr[HDR_OVF_BIT]               = ovf;
    hdr[HDR_SIZE_MSB:HDR_SIZE_LSB] = size;
    return hdr;
  endfunction

  // Pick byte idx of a record, most significant byte first:
  // 0 header, 1..4 address MSB..LSB, 5..8 data MSB..LSB.
  function automatic logic [7:0] record_byte(input logic [RECORD_WIDTH-1:0] rec,
                                             input logic [IDX_W-1:0]        idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = rec[71:64];
      4'd1:    b = rec[63:56];
      4'd2:    b = rec[55:48];
      4'd3:    b = rec[47:40];
      4'd4:    b = rec[39:32];
      4'd5:    b = rec[31:24];
      4'd6:    b = rec[23:16];
      4'd7:    b = rec[15:8];
      4'd8:    b = rec[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lpc_sync_fifo.sv
// Generic single-clock FIFO. Push is ignored when full and pop when empty,
// both judged on the pre-edge level. Read data is the head entry, shown
// combinationally so a pop and its data happen on the same edge.
module lpc_sync_fifo #(
  parameter  int WIDTH = 72,
  parameter  int DEPTH = 16,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap naturally (DEPTH is 2^n)
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are meaningless until written, so no reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/lpc_record_fifo.sv
// Captures decoded LPC cycles as 9-byte records, queues them, and streams
// them out one byte at a time over a valid/ready handshake. Records that
// arrive while the queue is full are dropped, counted, and flagged in the
// header of the next record that is accepted.
module lpc_record_fifo
  import lpc_sniff_pkg::*;
#(
  parameter  int DEPTH   = 16,
  localparam int LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic               lpc_clock,
  input  logic               lpc_reset,
  input  logic [3:0]         in_cyctype_dir,
  input  logic [31:0]        in_addr,
  input  logic [31:0]        in_data,
  input  logic [2:0]         in_data_size,
  input  logic               in_clock_enable,
  output logic [7:0]         out_byte,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LEVEL_W-1:0] fifo_level,
  output logic [7:0]         drop_count
);

  logic [RECORD_WIDTH-1:0] record_in;
  logic [RECORD_WIDTH-1:0] fifo_rdata;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    drop;

  logic                    ovf_q, ovf_d;
  logic [7:0]              drop_count_q, drop_count_d;
  ser_state_t              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [RECORD_WIDTH-1:0] rec_q, rec_d;

  lpc_sync_fifo #(
    .WIDTH (RECORD_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (lpc_clock),
    .rst   (lpc_reset),
    .push  (fifo_push),
    .wdata (record_in),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Capture side: accept or drop the strobed record, track overflow status.
  // Fullness is the pre-edge level, so a same-edge pop never makes room.
  always_comb begin
    fifo_push    = in_clock_enable && !fifo_full;
    drop         = in_clock_enable && fifo_full;
    record_in    = {make_header(in_cyctype_dir, ovf_q, in_data_size), in_addr, in_data};
    ovf_d        = ovf_q;
    drop_count_d = drop_count_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
    end else if (fifo_push && ovf_q) begin
      // The flag has just been written into an accepted header
      ovf_d = 1'b0;
    end
  end

  // Serializer next-state: load a record from the queue, walk its bytes as
  // the consumer accepts them, and chain straight into the next record.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rec_d    = rec_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          rec_d    = fifo_rdata;
          idx_d    = '0;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              rec_d    = fifo_rdata;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Control registers, cleared asynchronously
  always_ff @(posedge lpc_clock or posedge lpc_reset) begin
    if (lpc_reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      ovf_q        <= 1'b0;
      drop_count_q <= 8'h00;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      ovf_q        <= ovf_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Record being serialized; only observed while in SEND
  always_ff @(posedge lpc_clock) begin
    rec_q <= rec_d;
  end

  // Output is gated by state so it reads 0x00 whenever nothing is offered,
  // including immediately on reset
  assign out_valid  = (state_q == ST_SEND);
  assign out_byte   = out_valid ? record_byte(rec_q, idx_q) : 8'h00;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_lpc_record_fifo.sv
// Directed bench for lpc_record_fifo: single record, back-to-back records,
// backpressure, overflow flagging, drop-count saturation and mid-record reset.
module tb_lpc_record_fifo;

  localparam int DEPTH   = 16;
  localparam int LEVEL_W = $clog2(DEPTH) + 1;

  logic               lpc_clock;
  logic               lpc_reset;
  logic [3:0]         in_cyctype_dir;
  logic [31:0]        in_addr;
  logic [31:0]        in_data;
  logic [2:0]         in_data_size;
  logic               in_clock_enable;
  logic [7:0]         out_byte;
  logic               out_valid;
  logic               out_ready;
  logic [LEVEL_W-1:0] fifo_level;
  logic [7:0]         drop_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  lpc_record_fifo #(.DEPTH(DEPTH)) dut (
    .lpc_clock       (lpc_clock),
    .lpc_reset       (lpc_reset),
    .in_cyctype_dir  (in_cyctype_dir),
    .in_addr         (in_addr),
    .in_data         (in_data),
    .in_data_size    (in_data_size),
    .in_clock_enable (in_clock_enable),
    .out_byte        (out_byte),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .fifo_level      (fifo_level),
    .drop_count      (drop_count)
  );

  initial lpc_clock = 1'b0;
  always #5 lpc_clock = ~lpc_clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge lpc_clock);
    #1;
  endtask

  task automatic strobe(input logic [3:0] ct, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] sz);
    in_cyctype_dir  = ct;
    in_addr         = a;
    in_data         = d;
    in_data_size    = sz;
    in_clock_enable = 1'b1;
    tick();
    in_clock_enable = 1'b0;
  endtask

  // Queue the nine bytes of a record; the header is given hand-computed
  task automatic expect_rec(input logic [7:0] h, input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back(h);
    for (int k = 3; k >= 0; k--) exp_q.push_back(8'((a >> (8 * k)) & 32'hFF));
    for (int k = 3; k >= 0; k--) exp_q.push_back(8'((d >> (8 * k)) & 32'hFF));
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
    end
    check(tag, out_valid, 1'b1);
  endtask

  // Consume expected bytes with out_ready held high
  task automatic drain(input string tag, input bit no_gap);
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 2000) begin
      if (out_valid) check(tag, out_byte, exp_q.pop_front());
      else if (no_gap) check({tag, "_gap"}, out_valid, 1'b1);
      tick();
      guard++;
    end
    if (exp_q.size() > 0) begin
      check({tag, "_timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic pulse_reset;
    lpc_reset = 1'b1;
    tick();
    tick();
    lpc_reset = 1'b0;
    tick();
  endtask

  initial begin
    lpc_reset       = 1'b1;
    in_cyctype_dir  = 4'h0;
    in_addr         = 32'h0;
    in_data         = 32'h0;
    in_data_size    = 3'd0;
    in_clock_enable = 1'b0;
    out_ready       = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_valid", out_valid, 1'b0);
    check("rst_byte", out_byte, 8'h00);
    check("rst_level", fifo_level, 0);
    check("rst_drop", drop_count, 0);
    lpc_reset = 1'b0;
    tick();

    // Single I/O read
    out_ready = 1'b1;
    strobe(4'h0, 32'h0000_7fe5, 32'h0000_006c, 3'd1);
    check("single_lat_level", fifo_level, 1);
    check("single_lat_valid", out_valid, 1'b0);
    tick();
    check("single_valid", out_valid, 1'b1);
    expect_rec(8'h01, 32'h0000_7fe5, 32'h0000_006c);
    drain("single", 1'b1);
    check("single_end_valid", out_valid, 1'b0);
    check("single_end_level", fifo_level, 0);

    // Back-to-back strobes: 27 bytes with no gap, in order
    expect_rec(8'h24, 32'h1122_3344, 32'hAABB_CCDD);
    expect_rec(8'h31, 32'h0000_0080, 32'h0000_0055);
    expect_rec(8'h02, 32'hDEAD_BEEF, 32'h0102_0304);
    fork
      begin
        strobe(4'h2, 32'h1122_3344, 32'hAABB_CCDD, 3'd4);
        strobe(4'h3, 32'h0000_0080, 32'h0000_0055, 3'd1);
        strobe(4'h0, 32'hDEAD_BEEF, 32'h0102_0304, 3'd2);
      end
      begin
        wait_valid("b2b_start", 10);
        drain("b2b", 1'b1);
      end
    join
    check("b2b_end_valid", out_valid, 1'b0);

    // Backpressure at byte 3
    strobe(4'h0, 32'h0000_7fe5, 32'h0000_006c, 3'd1);
    tick();
    expect_rec(8'h01, 32'h0000_7fe5, 32'h0000_006c);
    for (int i = 0; i < 3; i++) begin
      check("bp_pre", out_byte, exp_q.pop_front());
      tick();
    end
    check("bp_byte3", out_byte, 8'h7F);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_byte", out_byte, 8'h7F);
    end
    out_ready = 1'b1;
    drain("bp_resume", 1'b1);
    check("bp_end_valid", out_valid, 1'b0);

    // Overflow: one record parks in the serializer, then 18 strobes leave
    // 16 queued and 2 dropped
    out_ready = 1'b0;
    strobe(4'h6, 32'hCAFE_0000, 32'h1234_5678, 3'd4);
    tick();
    check("ovf_primer_level", fifo_level, 0);
    check("ovf_primer_valid", out_valid, 1'b1);
    for (int i = 0; i < 18; i++) strobe(4'h1, 32'h1000 + i, i, 3'd4);
    check("ovf_level", fifo_level, 16);
    check("ovf_drop", drop_count, 2);
    expect_rec(8'h64, 32'hCAFE_0000, 32'h1234_5678);
    for (int i = 0; i < 16; i++) expect_rec(8'h14, 32'h1000 + i, i);
    out_ready = 1'b1;
    drain("ovf_drain", 1'b1);
    check("ovf_drained_level", fifo_level, 0);
    check("ovf_drained_drop", drop_count, 2);
    strobe(4'h5, 32'h0000_000A, 32'h0000_000B, 3'd3);
    strobe(4'h5, 32'h0000_000C, 32'h0000_000D, 3'd3);
    expect_rec(8'h5B, 32'h0000_000A, 32'h0000_000B);
    expect_rec(8'h53, 32'h0000_000C, 32'h0000_000D);
    wait_valid("ovf_next_start", 10);
    drain("ovf_next", 1'b1);

    // Drop count saturation
    pulse_reset();
    check("sat_drop_cleared", drop_count, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) strobe(4'h7, i, i, 3'd1);
    check("sat_full_level", fifo_level, 16);
    for (int i = 0; i < 254; i++) strobe(4'h7, i, i, 3'd1);
    check("sat_254", drop_count, 254);
    strobe(4'h7, 0, 0, 3'd1);
    check("sat_255", drop_count, 255);
    for (int i = 0; i < 45; i++) strobe(4'h7, i, i, 3'd1);
    check("sat_hold", drop_count, 255);
    check("sat_level", fifo_level, 16);

    // Strobes during reset are ignored
    lpc_reset       = 1'b1;
    in_clock_enable = 1'b1;
    tick();
    tick();
    in_clock_enable = 1'b0;
    lpc_reset       = 1'b0;
    tick();
    check("rst_ign_level", fifo_level, 0);
    check("rst_ign_valid", out_valid, 1'b0);
    check("rst_ign_drop", drop_count, 0);

    // Reset mid-record with 3 records queued
    out_ready = 1'b0;
    strobe(4'hF, 32'h0102_0304, 32'h0506_0708, 3'd4);
    strobe(4'h1, 32'h1111_1111, 32'h2222_2222, 3'd4);
    strobe(4'h1, 32'h3333_3333, 32'h4444_4444, 3'd4);
    strobe(4'h1, 32'h5555_5555, 32'h6666_6666, 3'd4);
    check("mid_level", fifo_level, 3);
    check("mid_hdr", out_byte, 8'hF4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("mid_byte4", out_byte, 8'h04);
    #2;
    lpc_reset = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_byte", out_byte, 8'h00);
    tick();
    tick();
    lpc_reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("mid_quiet", out_valid, 1'b0);
    end
    check("mid_quiet_level", fifo_level, 0);
    strobe(4'h2, 32'h0000_03F8, 32'h0000_00A5, 3'd2);
    expect_rec(8'h22, 32'h0000_03F8, 32'h0000_00A5);
    wait_valid("mid_new_start", 10);
    drain("mid_new", 1'b1);
    check("mid_new_end", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
